control_pipe: RTL
=================

// Module: control_pipe
//
// PURPOSE
//  Next-generation main decoder for the pipelined RV32I(+M) core.
//  - Decodes op/funct3/funct7 in the Decode stage and registers the control word into the ID/EX boundary.
//  - Resolves branches and jumps in the Execute stage, and generates the flush to the front-end.
//  - Sequences multi-cycle MUL/DIV occupancy of the Execute stage with a busy FSM.
//
// PARAMETERS
//  MUL_CYCLES  2   cycles a MUL* instruction occupies EX (>=1)
//  DIV_CYCLES  16  cycles a DIV*/REM* instruction occupies EX (>=1)
//  CNT_W       $clog2(DIV_CYCLES+1)  busy-counter width (derived, do not override)
//
// PORTS
//  clk           in   1  core clock, all state on posedge
//  rst           in   1  synchronous reset, active-high
//  op_d          in   7  opcode, D stage
//  funct3_d      in   3  funct3, D stage
//  funct7_d      in   7  funct7 (bits 31:25), D stage
//  valid_d       in   1  D-stage instruction valid
//  stall_d       in   1  load-use stall from hazard unit (hold F/D, bubble E)
//  zero_e        in   1  ALU result == 0, E stage
//  lt_e          in   1  signed rs1 < rs2, E stage
//  ltu_e         in   1  unsigned rs1 < rs2, E stage
//  ImmSrc_d      out  3  immediate type, combinational D stage (000 I, 001 S, 010 B, 011 U, 100 J)
//  RegWrite_e    out  1  regfile write enable, E stage
//  MemWrite_e    out  1  data memory write enable, E stage
//  ALUSrc_e      out  1  ALU SrcB select (1 = imm)
//  ResultSrc_e   out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
//  ALUControl_e  out  5  ALU op; 0xxxx base ops, 1_0fff = M op with funct3 fff
//  AddrMode_e    out  2  00 byte, 01 half, 10 word
//  LoadUns_e     out  1  zero-extend load (LBU/LHU)
//  PCSrc_e       out  2  00 PC+4, 01 PC+imm, 10 ALU (jalr), 11 hold PC
//  Flush_fd      out  1  flush F/D; asserted when PCSrc_e is 01 or 10
//  Stall_fde     out  1  hold F, D and E stages (MUL/DIV busy)
//  Illegal_e     out  1  unsupported encoding reached E (converted to a NOP)
//
// BEHAVIOUR
//  - Reset: all *_e outputs 0, PCSrc_e = 00, Flush_fd = 0, Stall_fde = 0, FSM in IDLE, counter 0.
//  - Decode is combinational and registered once, so control latency D->E is 1 cycle.
//  - Base ALU encodings:
//      0000 add   0001 sub   0010 and   0011 or    0100 xor
//      0101 sll   0110 sra   0111 srl   1000 slt   1001 sltu
//  - SUB is selected only when the opcode is R-type and funct7[5] = 1.
//  - SRAI is decoded from funct7[5] for both R-type and I-type shifts.
//  - Loads and stores: LB/LH/LW/LBU/LHU and SB/SH/SW set AddrMode_e and LoadUns_e.
//  - Branches (E stage), combinational from the registered branch type:
//      beq zero   bne !zero   blt lt   bge !lt   bltu ltu   bgeu !ltu
//  - Jumps: jal gives PCSrc = 01; jalr gives PCSrc = 10; both set ResultSrc = 10.
//  - ID/EX register update, in priority order each posedge:
//      1. rst
//      2. Flush_fd -> bubble
//      3. Stall_fde -> hold
//      4. stall_d -> bubble
//      5. !valid_d -> bubble
//      6. otherwise capture
//    A bubble has every enable 0, PCSrc = 00 and Illegal = 0.
//  - Illegal encodings (unknown opcode, or funct7 = 0000001 when MULDIV_EN is off):
//    - captured as a NOP with Illegal_e = 1 for one E cycle;
//    - they never write the regfile or memory.
//  - MUL/DIV FSM:
//      IDLE -> BUSY when a valid M op enters E; the counter loads N-1 (N = MUL_CYCLES or DIV_CYCLES).
//      BUSY: Stall_fde = 1 and PCSrc_e = 11; the counter decrements each cycle.
//      BUSY -> IDLE when the counter reaches 0; that cycle Stall_fde = 0 and RegWrite_e = 1.
//      N = 1: no BUSY state, no stall.
//  - RegWrite_e for an M op is asserted only in its final EX cycle.
//  - Simultaneous events:
//    - flush beats stall_d;
//    - stall_d is ignored while BUSY, because Stall_fde already holds D;
//    - a branch cannot be in E while BUSY.
//  - Reset mid-BUSY returns to IDLE in one cycle with no write.
//
// CONFIGURATION
//  MULDIV_EN defined:
//  - RV32M is decoded (funct7 = 0000001, opcode 0110011);
//  - ALUControl_e = {2'b10, funct3};
//  - the FSM is present.
//  MULDIV_EN undefined:
//  - M encodings are Illegal_e NOPs;
//  - the FSM and counter are removed; Stall_fde is tied 0.
//
// TESTING
//  1. rst held 2 cycles, then released -> all outputs 0, PCSrc_e = 00.
//  2. R-type add, then sub, then srai (I-type, funct7 = 0100000) -> next-cycle ALUControl_e = 00000, 00001, 00110.
//  3. beq with zero_e = 1 -> PCSrc_e = 01, Flush_fd = 1; the next E is a bubble (RegWrite_e = 0).
//     bltu with ltu_e = 0 -> PCSrc_e = 00.
//  4. lhu -> AddrMode_e = 01, LoadUns_e = 1, ResultSrc_e = 01.
//     stall_d = 1 for one cycle -> E bubble and the D instruction is captured one cycle later.
//  5. MULDIV_EN on, div with DIV_CYCLES = 16 -> Stall_fde high 15 cycles; RegWrite_e = 1 only in cycle 16.
//     rst at cycle 5 -> IDLE, no write.
//  6. MULDIV_EN off, mul encoding -> Illegal_e = 1 for 1 cycle, RegWrite_e = 0, Stall_fde = 0.

Source files
------------

// File: rtl/control_pipe.sv
// control_pipe: RV32I(+M) main decoder with ID/EX control register, E-stage branch resolution
// and multi-cycle MUL/DIV busy sequencing. Define MULDIV_EN to decode RV32M and build the busy FSM.
module control_pipe #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_d,
    input  logic [2:0] funct3_d,
    input  logic [6:0] funct7_d,
    input  logic       valid_d,
    input  logic       stall_d,
    input  logic       zero_e,
    input  logic       lt_e,
    input  logic       ltu_e,
    output logic [2:0] ImmSrc_d,
    output logic       RegWrite_e,
    output logic       MemWrite_e,
    output logic       ALUSrc_e,
    output logic [1:0] ResultSrc_e,
    output logic [4:0] ALUControl_e,
    output logic [1:0] AddrMode_e,
    output logic       LoadUns_e,
    output logic [1:0] PCSrc_e,
    output logic       Flush_fd,
    output logic       Stall_fde,
    output logic       Illegal_e
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;

    typedef enum logic [1:0] {JMP_NONE, JMP_BRANCH, JMP_JAL, JMP_JALR} jump_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] result_src;
        logic [4:0] alu_ctl;
        logic [1:0] addr_mode;
        logic       load_uns;
        jump_t      jump;
        logic [2:0] br_funct3;
        logic       illegal;
    } ctl_t;

    localparam ctl_t CTL_BUBBLE = '0;

    if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || MUL_CYCLES > DIV_CYCLES) begin : g_bad_cfg
        $error("control_pipe: need 1 <= MUL_CYCLES <= DIV_CYCLES");
    end

    ctl_t       dec;
    ctl_t       ex;
    logic [4:0] base_alu;
    logic       taken;
    logic [1:0] pc_src;

`ifdef MULDIV_EN
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dec_cnt;
    logic             dec_mop;
    logic             dec_multi;
    logic             capture;
`endif

    // funct3 -> ALU op shared by R-type and I-type; funct7[5] picks SRA for both shift forms
    always_comb begin
        base_alu = ALU_ADD;
        case (funct3_d)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = funct7_d[5] ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    end

    always_comb begin
        dec      = CTL_BUBBLE;
        ImmSrc_d = 3'b000;
`ifdef MULDIV_EN
        dec_mop  = 1'b0;
`endif
        case (op_d)
            OP_R: begin
                if (funct7_d == 7'b0000001) begin
`ifdef MULDIV_EN
                    dec.reg_write = 1'b1;
                    dec.alu_ctl   = {2'b10, funct3_d};
                    dec_mop       = 1'b1;
`else
                    dec.illegal   = 1'b1;
`endif
                end else begin
                    dec.reg_write = 1'b1;
                    dec.alu_ctl   = (funct3_d == 3'b000 && funct7_d[5]) ? ALU_SUB : base_alu;
                end
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = base_alu;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                dec.addr_mode  = funct3_d[1:0];
                dec.load_uns   = funct3_d[2];
            end
            OP_STORE: begin
                ImmSrc_d      = 3'b001;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.addr_mode = funct3_d[1:0];
            end
            OP_BRANCH: begin
                ImmSrc_d      = 3'b010;
                dec.alu_ctl   = ALU_SUB;
                dec.jump      = JMP_BRANCH;
                dec.br_funct3 = funct3_d;
            end
            OP_JAL: begin
                ImmSrc_d       = 3'b100;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = JMP_JAL;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = JMP_JALR;
            end
            OP_LUI: begin
                ImmSrc_d       = 3'b011;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b11;
            end
            OP_AUIPC: begin
                ImmSrc_d      = 3'b011;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Branch condition from the registered funct3; unused branch funct3 codes never take
    always_comb begin
        taken = 1'b0;
        case (ex.br_funct3)
            3'b000:  taken = zero_e;
            3'b001:  taken = !zero_e;
            3'b100:  taken = lt_e;
            3'b101:  taken = !lt_e;
            3'b110:  taken = ltu_e;
            3'b111:  taken = !ltu_e;
            default: taken = 1'b0;
        endcase

        pc_src = 2'b00;
        if (Stall_fde) begin
            pc_src = 2'b11;
        end else begin
            case (ex.jump)
                JMP_BRANCH: pc_src = taken ? 2'b01 : 2'b00;
                JMP_JAL:    pc_src = 2'b01;
                JMP_JALR:   pc_src = 2'b10;
                default:    pc_src = 2'b00;
            endcase
        end
    end

    assign PCSrc_e  = pc_src;
    assign Flush_fd = (pc_src == 2'b01) || (pc_src == 2'b10);

`ifdef MULDIV_EN
    // DIV/REM have funct3[2] set; the counter must fit DIV_CYCLES, hence MUL_CYCLES <= DIV_CYCLES
    assign dec_multi = dec_mop && (funct3_d[2] ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1));
    assign dec_cnt   = funct3_d[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    assign capture   = !Flush_fd && !Stall_fde && !stall_d && valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture && dec_multi) begin
                        state <= BUSY;
                        cnt   <= dec_cnt;
                    end
                end
                default: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign Stall_fde = (state == BUSY);
`else
    assign Stall_fde = 1'b0;
`endif

    // ID/EX control register; a multi-cycle M op enters with its write held off until the last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ex <= CTL_BUBBLE;
        end else if (Flush_fd) begin
            ex <= CTL_BUBBLE;
        end else if (Stall_fde) begin
`ifdef MULDIV_EN
            if (cnt == CNT_W'(1)) begin
                ex.reg_write <= 1'b1;
            end
`endif
        end else if (stall_d || !valid_d) begin
            ex <= CTL_BUBBLE;
        end else begin
            ex <= dec;
`ifdef MULDIV_EN
            if (dec_multi) begin
                ex.reg_write <= 1'b0;
            end
`endif
        end
    end

    assign RegWrite_e   = ex.reg_write;
    assign MemWrite_e   = ex.mem_write;
    assign ALUSrc_e     = ex.alu_src;
    assign ResultSrc_e  = ex.result_src;
    assign ALUControl_e = ex.alu_ctl;
    assign AddrMode_e   = ex.addr_mode;
    assign LoadUns_e    = ex.load_uns;
    assign Illegal_e    = ex.illegal;

endmodule
